mac_accum: RTL and testbench
============================

MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter M, default 4: width of upstream multiplicand a.
REQ-002 SHALL have parameter N, default 4: width of upstream multiplier b.
REQ-003 SHALL have parameter K, default 4: number of products summed per result, legal range K >= 1.
REQ-004 SHALL have derived localparam ACC_W = M+N+$clog2(K), with a minimum of M+N when K=1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port prod, input, M+N bits: unsigned product from the upstream mult_mnbit stage.
REQ-008 SHALL have port in_valid, input, 1 bit: prod is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts prod this cycle.
REQ-010 SHALL have port clear, input, 1 bit: synchronous abort of the current accumulation.
REQ-011 SHALL have port acc_out, output, ACC_W bits: accumulated sum of K products.
REQ-012 SHALL have port out_valid, output, 1 bit: acc_out holds a completed result.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream consumes acc_out.

Function
REQ-014 SHALL transfer one input only when in_valid & in_ready are both high at a rising clk edge.
REQ-015 SHALL transfer one output only when out_valid & out_ready are both high at a rising clk edge.
REQ-016 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on accept, acc<=zero-extended prod and cnt<=1; next state is ACCUM, or DONE if K=1.
REQ-018 ACCUM: in_ready=1, out_valid=0; on accept, acc<=acc+prod and cnt<=cnt+1; next state is DONE when the accepted term is the K-th, otherwise ACCUM.
REQ-019 ACCUM with in_valid low SHALL hold acc and cnt unchanged; gaps of any length are legal.
REQ-020 DONE: in_ready=0, out_valid=1, acc_out=acc held stable; on output transfer, acc<=0 and cnt<=0 and next state is IDLE.
REQ-021 DONE with out_ready low SHALL stall indefinitely with acc_out unchanged; no input is accepted.
REQ-022 Output transfer in DONE SHALL NOT accept an input in the same cycle; the first term of the next group is accepted at the earliest in the following cycle.
REQ-023 acc_out SHALL be driven directly from the acc register (no combinational path from prod); outside DONE it shows the partial sum.
REQ-024 Throughput SHALL be K+1 cycles per result with no stalls; latency from the K-th accept to out_valid is 1 cycle.
REQ-025 Arithmetic SHALL be unsigned and of width ACC_W; overflow cannot occur, since K*(2^(M+N)-1) < 2^ACC_W.
REQ-026 clear=1 in any state SHALL force acc<=0, cnt<=0 and state<=IDLE next cycle, and SHALL discard any concurrent input or output transfer.
REQ-027 in_ready SHALL be low during any cycle in which clear=1.

Reset
REQ-028 rst_n=0 at a clk edge SHALL set state=IDLE, acc=0 and cnt=0; it overrides clear and any handshake, including mid-accumulation.
REQ-029 During reset, and in the first cycle after it, outputs SHALL be out_valid=0, acc_out=0 and in_ready=1 (in_ready=0 while rst_n=0).

Structure
REQ-030 A shared package mac_pkg SHALL hold the state enum type (IDLE, ACCUM, DONE) and the ACC_W calculation function.
REQ-031 One sub-module, term_counter, SHALL be used: a $clog2(K)+1-bit counter with inc, clr and a last-term flag output.
REQ-032 The adder SHALL be inferred inline; the block SHALL NOT instantiate the upstream multiplier.

Verification (M=N=4, K=4, ACC_W=10 unless stated)
REQ-033 Scenario 1: prods 225,225,225,225 back-to-back -> out_valid in cycle 5, acc_out=900.
REQ-034 Scenario 2: prods 1,2,3,4 with in_valid gaps of 2 cycles between terms -> acc_out=10; acc holds during gaps.
REQ-035 Scenario 3: result ready with out_ready low for 5 cycles -> out_valid and acc_out=10 stay stable, in_ready=0, then handshake -> IDLE.
REQ-036 Scenario 4: clear after 2 of 4 terms (7,9), then prods 5,5,5,5 -> acc_out=20; no residue of 16.
REQ-037 Scenario 5: rst_n low for 1 cycle mid-accumulation -> acc_out=0, out_valid=0, next group sums correctly.
REQ-038 Scenario 6: K=1, prod=200 -> out_valid on the next cycle, acc_out=200, ACC_W=8.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and accumulator width helper for mac_accum
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  function automatic int acc_w(input int m, input int n, input int k);
    return m + n + (k > 1 ? $clog2(k) : 0);
  endfunction

endpackage

// File: rtl/term_counter.sv
// term_counter: counts accepted terms of a group and flags when the next accept is the last one
module term_counter #(
  parameter int K = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_o
);

  localparam int CW = $clog2(K) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins over increment so an abort or an output transfer restarts the group
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + CW'(1) : cnt_q;

  // term count register
  always_ff @(posedge clk) cnt_q <= rst_n ? cnt_d : '0;

  assign last_o = cnt_q == CW'(K - 1);

endmodule

// File: rtl/mac_accum.sv
// mac_accum: sums groups of K unsigned products with valid/ready handshakes on both sides
module mac_accum
  import mac_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [M+N-1:0]            prod,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      clear,
  output logic [acc_w(M,N,K)-1:0]   acc_out,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int ACC_W = acc_w(M, N, K);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             accept, out_fire, last;

  assign in_ready  = rst_n & ~clear & (state_q != DONE);
  assign out_valid = rst_n & (state_q == DONE);
  assign acc_out   = acc_q;
  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready & ~clear;

  term_counter #(.K(K)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (accept),
    .clr_i  (clear | out_fire),
    .last_o (last)
  );

  // next state and accumulator: clear aborts, accept adds a term, output transfer empties
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
    end else if (accept) begin
      state_d = last ? DONE : ACCUM;
      acc_d   = (state_q == IDLE ? '0 : acc_q) + ACC_W'(prod);
    end else if (out_fire) begin
      state_d = IDLE;
      acc_d   = '0;
    end
  end

  // state and accumulator registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed checks of mac_accum with K=4 and K=1 instances
module tb_mac_accum;

  logic       clk = 0;
  logic       rst_n;
  logic [7:0] prod, prod1;
  logic       in_valid, in_valid1, clear, clear1, out_ready, out_ready1;
  logic       in_ready, in_ready1, out_valid, out_valid1;
  logic [9:0] acc_out;
  logic [7:0] acc_out1;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  mac_accum #(.M(4), .N(4), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  mac_accum #(.M(4), .N(4), .K(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .prod(prod1), .in_valid(in_valid1), .in_ready(in_ready1),
    .clear(clear1), .acc_out(acc_out1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; prod = 0; in_valid = 0; clear = 0; out_ready = 0;
    prod1 = 0; in_valid1 = 0; clear1 = 0; out_ready1 = 0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_acc_out", acc_out, 0);

    // scenario 1: 225 x4 back-to-back
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; prod = 225;
      tick();
      if (i < 3) check("s1_partial", acc_out, 225 * (i + 1));
    end
    in_valid = 0;
    check("s1_out_valid", out_valid, 1);
    check("s1_acc_out", acc_out, 900);
    check("s1_in_ready", in_ready, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("s1_idle_valid", out_valid, 0);
    check("s1_idle_acc", acc_out, 0);

    // scenario 2: 1,2,3,4 with two-cycle gaps and garbage prod during gaps
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; prod = 8'(i + 1);
      tick();
      if (i < 3) begin
        in_valid = 0; prod = 8'hFF;
        tick(); tick();
        check("s2_gap_hold", acc_out, (i + 1) * (i + 2) / 2);
        check("s2_gap_not_done", out_valid, 0);
      end
    end
    in_valid = 0;
    check("s2_out_valid", out_valid, 1);
    check("s2_acc_out", acc_out, 10);

    // scenario 3: stall five cycles while upstream offers data
    in_valid = 1; prod = 99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s3_stall_valid", out_valid, 1);
      check("s3_stall_acc", acc_out, 10);
      check("s3_stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    check("s3_no_same_cycle_accept", acc_out, 0);
    check("s3_idle_valid", out_valid, 0);
    check("s3_idle_in_ready", in_ready, 1);
    in_valid = 0;

    // scenario 4: clear after 7,9 then 5 x4
    in_valid = 1; prod = 7; tick();
    prod = 9; tick();
    check("s4_partial", acc_out, 16);
    prod = 50; clear = 1;
    #1 check("s4_clear_in_ready", in_ready, 0);
    tick();
    clear = 0;
    check("s4_cleared", acc_out, 0);
    for (int i = 0; i < 4; i++) begin
      prod = 5;
      tick();
    end
    in_valid = 0;
    check("s4_out_valid", out_valid, 1);
    check("s4_acc_out", acc_out, 20);
    out_ready = 1; tick(); out_ready = 0;

    // scenario 5: reset mid-accumulation then 15 x4
    in_valid = 1; prod = 10;
    tick(); tick(); tick();
    check("s5_partial", acc_out, 30);
    rst_n = 0;
    tick();
    check("s5_rst_acc", acc_out, 0);
    check("s5_rst_valid", out_valid, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      prod = 15;
      tick();
      if (i < 3) check("s5_partial_after", acc_out, 15 * (i + 1));
    end
    in_valid = 0;
    check("s5_out_valid", out_valid, 1);
    check("s5_acc_out", acc_out, 60);
    out_ready = 1; tick(); out_ready = 0;

    // scenario 6: K=1 single term of 200
    check("s6_in_ready", in_ready1, 1);
    in_valid1 = 1; prod1 = 200;
    tick();
    in_valid1 = 0;
    check("s6_out_valid", out_valid1, 1);
    check("s6_acc_out", acc_out1, 200);
    out_ready1 = 1;
    tick();
    out_ready1 = 0;
    check("s6_idle_valid", out_valid1, 0);
    check("s6_idle_acc", acc_out1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
